// File: rtl/int_ack_ctrl.sv
// Interrupt acknowledge controller: arbitrates pending status bits onto one CPU IRQ line,
// returns a one-hot clear pulse on acknowledge and enforces a post-service holdoff gap.
module int_ack_ctrl #(
    parameter int NINT    = 16,
    parameter int IDW     = 4,
    parameter int HOLDOFF = 8
) (
    input  logic            macPIClk,
    input  logic            macPIClkRst,
    input  logic            enable,
    input  logic [NINT-1:0] statusVec,
    input  logic            irqAck,
    output logic            irqOut,
    output logic [IDW-1:0]  irqId,
    output logic [NINT-1:0] clearVec,
    output logic [7:0]      spuriousCnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        CLEAR  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            irq_nxt;
    logic [IDW-1:0]  id_nxt;
    logic [NINT-1:0] clr_nxt;
    logic [7:0]      spur_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic            arb;

    function automatic logic [IDW-1:0] lowest_set(input logic [NINT-1:0] v);
        lowest_set = '0;
        for (int i = NINT - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDW'(i);
        end
    endfunction

    function automatic logic bit_at(input logic [NINT-1:0] v, input logic [IDW-1:0] id);
        bit_at = 1'b0;
        for (int i = 0; i < NINT; i++) begin
            if (IDW'(i) == id) bit_at = v[i];
        end
    endfunction

    function automatic logic [NINT-1:0] one_hot(input logic [IDW-1:0] id);
        one_hot = '0;
        for (int i = 0; i < NINT; i++) begin
            one_hot[i] = (IDW'(i) == id);
        end
    endfunction

    always_comb begin
        state_nxt = state;
        irq_nxt   = irqOut;
        id_nxt    = irqId;
        clr_nxt   = '0;
        spur_nxt  = spuriousCnt;
        cnt_nxt   = cnt;
        arb       = 1'b0;

        case (state)
            IDLE: arb = 1'b1;
            ASSERT: begin
                // Disable wins over a same-cycle acknowledge.
                if (!enable) begin
                    state_nxt = IDLE;
                    irq_nxt   = 1'b0;
                end else if (irqAck) begin
                    irq_nxt = 1'b0;
                    if (bit_at(statusVec, irqId)) begin
                        state_nxt = CLEAR;
                        clr_nxt   = one_hot(irqId);
                    end else begin
                        if (spuriousCnt != 8'hFF) spur_nxt = spuriousCnt + 8'd1;
                        if (HOLDOFF == 0) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = HOLD;
                            cnt_nxt   = 8'(HOLDOFF);
                        end
                    end
                end
            end
            CLEAR: begin
                irq_nxt = 1'b0;
                if (HOLDOFF == 0) begin
                    arb = 1'b1;
                end else begin
                    state_nxt = HOLD;
                    cnt_nxt   = 8'(HOLDOFF);
                end
            end
            HOLD: begin
                irq_nxt = 1'b0;
                if (cnt <= 8'd1) arb = 1'b1;
                else             cnt_nxt = cnt - 8'd1;
            end
            default: state_nxt = IDLE;
        endcase

        // Arbitration on leaving the gap lets the IRQ reassert without an idle bubble.
        if (arb) begin
            state_nxt = IDLE;
            irq_nxt   = 1'b0;
            if (enable && (statusVec != '0)) begin
                state_nxt = ASSERT;
                irq_nxt   = 1'b1;
                id_nxt    = lowest_set(statusVec);
            end
        end
    end

    always_ff @(posedge macPIClk) begin
        if (macPIClkRst) begin
            state       <= IDLE;
            irqOut      <= 1'b0;
            irqId       <= '0;
            clearVec    <= '0;
            spuriousCnt <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            irqOut      <= irq_nxt;
            irqId       <= id_nxt;
            clearVec    <= clr_nxt;
            spuriousCnt <= spur_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_int_ack_ctrl.sv
// Directed bench for int_ack_ctrl: one instance with an 8-cycle holdoff, one with none.
module tb_int_ack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] status;
    logic        ack;

    logic        irq_a, irq_b;
    logic [3:0]  id_a, id_b;
    logic [15:0] clr_a, clr_b;
    logic [7:0]  spur_a, spur_b;

    int nchk  = 0;
    int npass = 0;

    always #5 clk = ~clk;

    int_ack_ctrl #(.NINT(16), .IDW(4), .HOLDOFF(8)) dut_a (
        .macPIClk(clk), .macPIClkRst(rst), .enable(enable), .statusVec(status),
        .irqAck(ack), .irqOut(irq_a), .irqId(id_a), .clearVec(clr_a), .spuriousCnt(spur_a)
    );

    int_ack_ctrl #(.NINT(16), .IDW(4), .HOLDOFF(0)) dut_b (
        .macPIClk(clk), .macPIClkRst(rst), .enable(enable), .statusVec(status),
        .irqAck(ack), .irqOut(irq_b), .irqId(id_b), .clearVec(clr_b), .spuriousCnt(spur_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; status = '0; ack = 1'b0;
        step();
        step();
        check("rst_irq", irq_a, 0);
        check("rst_id", id_a, 0);
        check("rst_clr", clr_a, 0);
        check("rst_spur", spur_a, 0);
        rst = 1'b0;

        // Basic service with holdoff
        enable = 1'b1; status = 16'h0010;
        step();
        check("t1_irq", irq_a, 1);
        check("t1_id", id_a, 4);
        step();
        check("t1_irq_hold", irq_a, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t1_clr", clr_a, 16'h0010);
        check("t1_irq_clr", irq_a, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t1_gap_irq", irq_a, 0);
            check("t1_gap_clr", clr_a, 0);
        end
        step();
        check("t1_reassert", irq_a, 1);
        check("t1_reassert_id", id_a, 4);
        enable = 1'b0; status = '0;
        step();
        check("t1_disable", irq_a, 0);

        // Frozen id and spurious ack
        enable = 1'b1; status = 16'h8005;
        step();
        check("t2_irq", irq_a, 1);
        check("t2_id", id_a, 0);
        status = 16'h8004;
        step();
        check("t2_id_frozen", id_a, 0);
        check("t2_irq_withdrawn", irq_a, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t2_spur", spur_a, 1);
        check("t2_noclr", clr_a, 0);
        check("t2_irq_low", irq_a, 0);
        for (int i = 0; i < 7; i++) begin
            step();
            check("t2_gap_irq", irq_a, 0);
            check("t2_gap_clr", clr_a, 0);
        end
        step();
        check("t2_next_irq", irq_a, 1);
        check("t2_next_id", id_a, 2);

        // Disable beats a same-cycle ack
        enable = 1'b0; ack = 1'b1;
        step();
        ack = 1'b0;
        check("t3_irq", irq_a, 0);
        check("t3_clr", clr_a, 0);
        check("t3_spur", spur_a, 1);
        step();
        check("t3_clr_late", clr_a, 0);
        check("t3_irq_late", irq_a, 0);

        // Spurious counter saturation
        enable = 1'b1;
        for (int n = 0; n < 300; n++) begin
            status = 16'h0001;
            step();
            if (n == 0) check("t5_irq", irq_a, 1);
            status = 16'h0000; ack = 1'b1;
            step();
            ack = 1'b0;
            if (n == 99)  check("t5_spur_mid", spur_a, 101);
            if (n == 253) check("t5_spur_254", spur_a, 255);
            repeat (9) step();
        end
        check("t5_spur_sat", spur_a, 255);

        // Reset during CLEAR
        status = 16'h0010;
        step();
        check("t6_irq", irq_a, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t6_clr", clr_a, 16'h0010);
        rst = 1'b1;
        step();
        check("t6_rst_clr", clr_a, 0);
        check("t6_rst_irq", irq_a, 0);
        check("t6_rst_id", id_a, 0);
        check("t6_rst_spur", spur_a, 0);
        rst = 1'b0; status = '0;
        step();

        // Zero holdoff: re-assert right after CLEAR
        status = 16'h0003;
        step();
        check("t4_irq", irq_b, 1);
        check("t4_id", id_b, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t4_clr", clr_b, 16'h0001);
        check("t4_irq_clr", irq_b, 0);
        step();
        check("t4_reassert", irq_b, 1);
        check("t4_reassert_id", id_b, 0);
        check("t4_clr_done", clr_b, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
